// File: rtl/chunked_addsub_seq.sv
// Multi-cycle wide adder/subtractor: processes CHUNK bits per cycle with a registered
// carry/borrow between chunks, valid/ready on both sides, flags delivered with the result.
module chunked_addsub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             sub_q, carry_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q, cout_q, ovf_q, zero_q;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;
  logic             last_chunk, msb_cin;

  // Operand registers shift right each RUN cycle, so the active chunk is always the low bits.
  always_comb begin
    chunk_sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    res_next   = result_q;
    for (int j = 0; j < int'(NCHUNK); j++) begin
      if (cnt_q == CW'(j)) res_next[j*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
    last_chunk = (cnt_q == CW'(NCHUNK - 1));
    // Carry into the MSB recovered from the MSB sum bit.
    msb_cin    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            sub_q   <= op_sub;
            carry_q <= op_sub ? ~cin : cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q <= res_next;
          carry_q  <= chunk_sum[CHUNK];
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          cnt_q    <= cnt_q + CW'(1);
          if (last_chunk) begin
            cout_q      <= sub_q ^ chunk_sum[CHUNK];
            ovf_q       <= msb_cin ^ chunk_sum[CHUNK];
            zero_q      <= (res_next == '0);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
